// File: rtl/register_scoreboard_if.sv
// register_scoreboard_if
//   Groups the scoreboard's dispatch, commit and status signals.
//   Parameters ND / NS size the D and S register address fields and busy vectors.
//   master : the CPU side (dispatch, reorder-buffer commit, flush request)
//   slave  : the scoreboard itself
//   Allocation : alloc_valid, alloc_use_rw, alloc_rw_addr, alloc_use_rs, alloc_rs_addr
//   Commit     : commit_valid, commit_use_rw, commit_rw_addr, commit_use_rs,
//                commit_rs_addr, commit_ready
//   Control    : flush, flush_busy, d_busy, s_busy, retire_pulse, error
interface register_scoreboard_if #(
  parameter int ND = 8,
  parameter int NS = 4
) ();
  logic                  alloc_valid;
  logic                  alloc_use_rw;
  logic [$clog2(ND)-1:0] alloc_rw_addr;
  logic                  alloc_use_rs;
  logic [$clog2(NS)-1:0] alloc_rs_addr;

  logic                  commit_valid;
  logic                  commit_use_rw;
  logic [$clog2(ND)-1:0] commit_rw_addr;
  logic                  commit_use_rs;
  logic [$clog2(NS)-1:0] commit_rs_addr;
  logic                  commit_ready;

  logic                  flush;
  logic                  flush_busy;
  logic [ND-1:0]         d_busy;
  logic [NS-1:0]         s_busy;
  logic                  retire_pulse;
  logic                  error;

  modport master (
    output alloc_valid, alloc_use_rw, alloc_rw_addr, alloc_use_rs, alloc_rs_addr,
    output commit_valid, commit_use_rw, commit_rw_addr, commit_use_rs, commit_rs_addr,
    output flush,
    input  commit_ready, flush_busy, d_busy, s_busy, retire_pulse, error
  );

  modport slave (
    input  alloc_valid, alloc_use_rw, alloc_rw_addr, alloc_use_rs, alloc_rs_addr,
    input  commit_valid, commit_use_rw, commit_rw_addr, commit_use_rs, commit_rs_addr,
    input  flush,
    output commit_ready, flush_busy, d_busy, s_busy, retire_pulse, error
  );
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard
//   Tracks outstanding register writes between dispatch and reorder-buffer
//   commit. One saturating pending-write counter per D and per S register;
//   a register reads busy while its counter is non-zero. A flush request
//   starts a sweep that clears one D and one S counter per cycle, during
//   which commits are stalled, allocations are ignored and every register
//   reads busy.
//
//   Ports
//     clk  : clock, all state on the rising edge
//     rst  : synchronous active-high reset
//     bus  : register_scoreboard_if.slave (allocation, commit, flush, status)
//
//   Parameters
//     L  : reorder-buffer depth; counters are $clog2(L)+1 bits and saturate at L
//     ND : number of D registers (NUM_D_REG from nand_cpu.svh)
//     NS : number of S registers (NUM_S_REG from nand_cpu.svh)
//
//   Build option
//     SCOREBOARD_BYPASS_EN : when defined, a register whose counter is 1 and
//       is being decremented by the current commit reads not-busy in that
//       same cycle; otherwise busy drops the cycle after the commit.
`ifndef NUM_D_REG
`define NUM_D_REG 8
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 4
`endif

module register_scoreboard #(
  parameter int L  = 16,
  parameter int ND = `NUM_D_REG,
  parameter int NS = `NUM_S_REG
) (
  input logic                  clk,
  input logic                  rst,
  register_scoreboard_if.slave bus
);

  localparam int CW   = $clog2(L) + 1;
  localparam int MAXR = (ND > NS) ? ND : NS;
  localparam int IW   = (MAXR > 1) ? $clog2(MAXR) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  cnt_t            d_cnt [ND];
  cnt_t            d_cnt_nxt [ND];
  cnt_t            s_cnt [NS];
  cnt_t            s_cnt_nxt [NS];
  logic [ND-1:0]   d_inc, d_dec, d_err;
  logic [NS-1:0]   s_inc, s_dec, s_err;
  logic            commit_acc;
  logic            err_set;
  logic            err_q;
  logic            retire_q;

  // Returns {error, next_count}. A simultaneous increment and decrement cancel;
  // overflow past L or underflow below 0 holds the count and flags an error.
  function automatic logic [CW:0] sat_step(input cnt_t cnt, input logic inc, input logic dec);
    if (inc && !dec) begin
      if (cnt == CW'(L)) return {1'b1, cnt};
      return {1'b0, cnt_t'(cnt + 1'b1)};
    end
    if (dec && !inc) begin
      if (cnt == '0) return {1'b1, cnt};
      return {1'b0, cnt_t'(cnt - 1'b1)};
    end
    return {1'b0, cnt};
  endfunction

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    commit_acc = 1'b0;
    d_inc      = '0;
    d_dec      = '0;
    d_err      = '0;
    s_inc      = '0;
    s_dec      = '0;
    s_err      = '0;
    d_cnt_nxt  = d_cnt;
    s_cnt_nxt  = s_cnt;
    case (state)
      RUN: begin
        // A flush request wins over this cycle's allocation and commit.
        if (bus.flush) begin
          state_nxt = FLUSH;
          idx_nxt   = '0;
        end else begin
          commit_acc = bus.commit_valid;
          for (int i = 0; i < ND; i++) begin
            d_inc[i] = bus.alloc_valid & bus.alloc_use_rw & (int'(bus.alloc_rw_addr) == i);
            d_dec[i] = commit_acc & bus.commit_use_rw & (int'(bus.commit_rw_addr) == i);
            {d_err[i], d_cnt_nxt[i]} = sat_step(d_cnt[i], d_inc[i], d_dec[i]);
          end
          for (int i = 0; i < NS; i++) begin
            s_inc[i] = bus.alloc_valid & bus.alloc_use_rs & (int'(bus.alloc_rs_addr) == i);
            s_dec[i] = commit_acc & bus.commit_use_rs & (int'(bus.commit_rs_addr) == i);
            {s_err[i], s_cnt_nxt[i]} = sat_step(s_cnt[i], s_inc[i], s_dec[i]);
          end
        end
      end
      FLUSH: begin
        // One D and one S counter cleared per cycle; a further flush request is ignored.
        for (int i = 0; i < ND; i++)
          if (int'(idx) == i) d_cnt_nxt[i] = '0;
        for (int i = 0; i < NS; i++)
          if (int'(idx) == i) s_cnt_nxt[i] = '0;
        if (idx == IW'(MAXR - 1)) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = IW'(idx + 1'b1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign err_set = (|d_err) | (|s_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      idx      <= '0;
      err_q    <= 1'b0;
      retire_q <= 1'b0;
      for (int i = 0; i < ND; i++) d_cnt[i] <= '0;
      for (int i = 0; i < NS; i++) s_cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      err_q    <= err_q | err_set;
      retire_q <= commit_acc;
      d_cnt    <= d_cnt_nxt;
      s_cnt    <= s_cnt_nxt;
    end
  end

  // Status outputs are held at their reset values while rst is high, even
  // before the first clock edge has loaded the state registers.
  always_comb begin
    bus.commit_ready = rst | (state == RUN);
    bus.flush_busy   = ~rst & (state == FLUSH);
    bus.retire_pulse = ~rst & retire_q;
    bus.error        = ~rst & err_q;
    bus.d_busy       = '0;
    bus.s_busy       = '0;
    if (!rst) begin
      if (state == FLUSH) begin
        bus.d_busy = '1;
        bus.s_busy = '1;
      end else begin
        for (int i = 0; i < ND; i++) begin
          bus.d_busy[i] = (d_cnt[i] != '0);
`ifdef SCOREBOARD_BYPASS_EN
          if (d_cnt[i] == cnt_t'(1) && d_dec[i] && !d_inc[i]) bus.d_busy[i] = 1'b0;
`endif
        end
        for (int i = 0; i < NS; i++) begin
          bus.s_busy[i] = (s_cnt[i] != '0);
`ifdef SCOREBOARD_BYPASS_EN
          if (s_cnt[i] == cnt_t'(1) && s_dec[i] && !s_inc[i]) bus.s_busy[i] = 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 Parameter L, default 16: reorder-buffer depth; pending counters are $clog2(L)+1 bits wide.
REQ-002 Parameters ND = `NUM_D_REG and NS = `NUM_S_REG, taken from nand_cpu.svh: the register counts.
REQ-003 Clock and reset are fixed.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 Allocation port (dispatch side, same cycle as the reorder-buffer push):
- alloc_valid  in  1  an entry is allocated this cycle.
- alloc_use_rw  in  1  the entry writes a D register.
- alloc_rw_addr  in  $clog2(ND)  D register index.
- alloc_use_rs  in  1  the entry writes an S register.
- alloc_rs_addr  in  $clog2(NS)  S register index.
REQ-005 Commit port, driven by the reorder-buffer commit output:
- commit_valid  in  1  head entry is done.
- commit_use_rw  in  1  head entry writes a D register.
- commit_rw_addr  in  $clog2(ND)  D register index.
- commit_use_rs  in  1  head entry writes an S register.
- commit_rs_addr  in  $clog2(NS)  S register index.
- commit_ready  out  1  a commit is accepted when commit_valid & commit_ready.
REQ-006 Control and status:
- flush  in  1  squash request.
- flush_busy  out  1  flush sweep in progress.
- d_busy  out  ND  bit i set while D register i has a pending write.
- s_busy  out  NS  bit i set while S register i has a pending write.
- retire_pulse  out  1  registered; 1 for one cycle after each accepted commit.
- error  out  1  sticky over/underflow flag.

Function
REQ-007 The block SHALL keep one pending-write counter per D register and one per S register.
REQ-008 Allocation in RUN SHALL increment counter[alloc_rw_addr] when alloc_valid & alloc_use_rw, and counter[alloc_rs_addr] when alloc_valid & alloc_use_rs.
REQ-009 An accepted commit SHALL decrement counter[commit_rw_addr] if commit_use_rw, and counter[commit_rs_addr] if commit_use_rs.
REQ-010 An increment and a decrement on the same counter in the same cycle SHALL leave that counter unchanged.
REQ-011 A decrement of a zero counter SHALL leave the counter at 0 and set error.
REQ-012 An increment of a counter already holding L SHALL leave the counter at L and set error.
REQ-013 d_busy[i] / s_busy[i] SHALL equal (counter != 0) in RUN.
REQ-014 FSM states are RUN and FLUSH.
- RUN to FLUSH: flush asserted in RUN; index resets to 0.
- FLUSH to RUN: after the cycle that clears index max(ND,NS)-1.
REQ-015 In FLUSH the block SHALL clear D counter[index] (if index<ND) and S counter[index] (if index<NS) each cycle, then increment index.
REQ-016 In FLUSH: commit_ready=0, alloc ignored, all d_busy/s_busy bits forced to 1, flush_busy=1.
REQ-017 flush asserted while already in FLUSH SHALL be ignored; the sweep SHALL continue uninterrupted.
REQ-018 commit_ready SHALL be 1 in RUN; flush asserted in RUN SHALL take priority over alloc and commit that cycle (both dropped).
REQ-019 retire_pulse SHALL be asserted exactly one cycle after each accepted commit.

Reset
REQ-020 While rst=1: all counters 0, state RUN, index 0, error 0, retire_pulse 0, d_busy/s_busy all 0, commit_ready 1, flush_busy 0.
REQ-021 rst asserted mid-flush SHALL abort the sweep, and the block SHALL be in RUN the cycle after rst deasserts.

Configuration
REQ-022 Macro SCOREBOARD_BYPASS_EN controls commit bypass.
- Defined: a counter equal to 1 and being decremented by an accepted commit SHALL show busy=0 in the same cycle, combinationally.
- Not defined: busy SHALL clear one cycle after the commit.

Verification
REQ-023 Alloc D3 and alloc D3 again, then commit D3 twice -> d_busy[3] stays 1 until the second commit, and is 0 afterwards (timing per REQ-022).
REQ-024 Same-cycle alloc and commit of S1 with counter=1 -> counter stays 1 and s_busy[1]=1.
REQ-025 Commit D5 with counter=0 -> error=1 and stays 1 until rst; counter stays 0.
REQ-026 L allocs to D0, then one more alloc -> counter=L and error=1.
REQ-027 Flush with ND=8, NS=4 -> flush_busy high for 8 cycles, commit_ready=0 throughout, then all busy bits=0; rst on cycle 3 of the sweep -> RUN next cycle.
REQ-028 Accepted commit -> retire_pulse=1 on the next cycle only; commit_valid with commit_ready=0 -> no pulse.
